// File: rtl/router_sync_n.sv
// Router synchronizer for NUM_CH output FIFOs: address latch, write/full steering,
// per-channel valid and read-timeout soft reset. Optional ROUTER_SYNC_TOUT_STATS_EN adds pulse counters.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                detect_add,
  input  logic [ADDR_W-1:0]   data_in,
  input  logic                write_en_reg,
  input  logic [NUM_CH-1:0]   read_en,
  input  logic [NUM_CH-1:0]   full,
  input  logic [NUM_CH-1:0]   empty,
  output logic [NUM_CH-1:0]   write_en,
  output logic                fifo_full,
  output logic [NUM_CH-1:0]   valid_out,
  output logic [NUM_CH-1:0]   soft_reset,
  output logic                addr_err
`ifdef ROUTER_SYNC_TOUT_STATS_EN
  ,
  output logic [8*NUM_CH-1:0] tout_cnt
`endif
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   NUM_CH_X = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_p1;
  logic              addr_valid_p1;
  logic              in_range_p0;
  logic [NUM_CH-1:0] sel_p1;
  logic [NUM_CH-1:0] stall_p0;
  logic [NUM_CH-1:0] hit_p0;
  logic [CNT_W-1:0]  cnt_p1 [NUM_CH];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_range_p0 = ({1'b0, data_in} < NUM_CH_X);

  // stage p0 -> p1: destination address latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p1       <= '0;
      addr_valid_p1 <= 1'b0;
      addr_err      <= 1'b0;
    end else if (detect_add) begin
      addr_p1       <= data_in;
      addr_valid_p1 <= in_range_p0;
      addr_err      <= ~in_range_p0;
    end
  end

  // One-hot select from the latched address; an out-of-range address selects nothing.
  always_comb begin
    sel_p1 = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel_p1[i] = addr_valid_p1 && (addr_p1 == ADDR_W'(i));
  end

  assign write_en  = write_en_reg ? sel_p1 : '0;
  assign fifo_full = |(full & sel_p1);
  assign valid_out = ~empty;

  assign stall_p0 = ~empty & ~read_en;

  always_comb begin
    hit_p0 = '0;
    for (int i = 0; i < NUM_CH; i++)
      hit_p0[i] = stall_p0[i] && (cnt_p1[i] == CNT_LAST);
  end

  // stage p0 -> p1: per-channel stall counters and flush pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      soft_reset <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
    end else begin
      soft_reset <= hit_p0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!stall_p0[i] || hit_p0[i]) cnt_p1[i] <= '0;
        else                           cnt_p1[i] <= cnt_p1[i] + 1'b1;
      end
    end
  end

`ifdef ROUTER_SYNC_TOUT_STATS_EN
  // Pulses never occur back to back, so every hit is a rising edge of soft_reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tout_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (hit_p0[i]) tout_cnt[8*i +: 8] <= sat_inc8(tout_cnt[8*i +: 8]);
    end
  end
`endif

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised successor to the 3-port router synchronizer: it connects the router FSM to NUM_CH output FIFOs. It latches the packet destination address and steers the FIFO write-enable and full status. It generates per-channel valid_out and a per-channel read-timeout soft reset. It adds invalid-address detection and a single-cycle soft-reset pulse with a parametrised timeout.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, destination address width; 2**ADDR_W >= NUM_CH required
TIMEOUT, 30, consecutive stalled cycles before soft reset (>= 2)
CNT_W, $clog2(TIMEOUT), timeout counter width (local, derived)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
detect_add  in  1  FSM strobe: data_in holds destination address
data_in  in  ADDR_W  destination address
write_en_reg  in  1  FSM request to write the current byte
read_en  in  NUM_CH  per-channel read strobe from downstream
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
write_en  out  NUM_CH  one-hot FIFO write enable
fifo_full  out  1  full flag of the currently addressed FIFO
valid_out  out  NUM_CH  per-channel data-available
soft_reset  out  NUM_CH  per-channel FIFO flush pulse
addr_err  out  1  latched address is out of range

Behaviour:
- Reset (async, active-high): addr=0, addr_valid=0, addr_err=0, all cnt=0, soft_reset=0.
- Address latch (registered):
  - On a posedge with detect_add=1: addr<=data_in; addr_valid<=(data_in<NUM_CH); addr_err<=(data_in>=NUM_CH).
  - Otherwise addr, addr_valid and addr_err hold. No X states.
- write_en (combinational): write_en[i] = write_en_reg & addr_valid & (addr==i).
  - Uses the registered addr, so detect_add in the same cycle affects write_en only from the next cycle.
  - At most one bit is set.
- fifo_full (combinational): full[addr] when addr_valid, else 0.
  - When addr_err=1 the FSM sees not-full, and writes are silently dropped because write_en=0.
- valid_out[i] = ~empty[i], combinational, zero latency.
- Timeout, per channel i, independent, evaluated each posedge with stall_i = ~empty[i] & ~read_en[i]:
  - If ~stall_i: cnt[i]<=0, soft_reset[i]<=0.
  - Else if cnt[i]==TIMEOUT-1: soft_reset[i]<=1, cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
- Result: soft_reset[i] is high for exactly one cycle, starting after the TIMEOUT-th consecutive stalled edge.
  - A read_en or empty on any edge restarts the count.
  - If the FIFO is still non-empty after the pulse, counting restarts from 0 and the next pulse comes TIMEOUT cycles later.
- read_en[i] together with ~empty[i] on the terminal edge: no pulse, counter cleared (read wins).
- Reset asserted mid-count or mid-pulse: soft_reset drops immediately (async), counters cleared.
- Channels never interact; simultaneous pulses on several channels are legal.

Optional Feature:
ROUTER_SYNC_TOUT_STATS_EN: adds output tout_cnt [8*NUM_CH-1:0]. Each 8-bit field i counts soft_reset[i] pulses.
- Increments on the edge that raises soft_reset[i].
- Saturates at 255; cleared only by reset.
- Without the macro the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: raise reset during a stall count of 10 -> soft_reset=0 and addr_err=0 immediately; after release a full 30-cycle stall is needed before the next pulse.
- Address steering, NUM_CH=3: detect_add with data_in=2, then write_en_reg=1 -> write_en=3'b100 from the next cycle; full=3'b100 -> fifo_full=1, full=3'b011 -> fifo_full=0.
- Invalid address: detect_add with data_in=3 -> addr_err=1 next cycle; write_en_reg=1 -> write_en=0, fifo_full=0; then detect_add with data_in=0 -> addr_err=0, write_en=3'b001.
- Same-cycle update: detect_add (data_in=1) and write_en_reg=1 while the latched addr is 0 -> write_en=3'b001 that cycle, 3'b010 the next.
- Timeout: empty[0]=0, read_en[0]=0 held -> soft_reset[0] high exactly one cycle after the 30th edge; held for 60 cycles -> two pulses, 30 cycles apart.
- Read abort: stall 29 cycles, read_en[0]=1 on the 30th edge -> no pulse; a fresh 30-cycle stall is needed. With ROUTER_SYNC_TOUT_STATS_EN, 300 pulses leave tout_cnt[7:0]=255.
